// File: rtl/pentary_xbar_pkg.sv
// Shared pentary definitions: digit encodings, digit-valid check, scheduler FSM states
// and crossbar address packing.
package pentary_xbar_pkg;

    localparam int DIGIT_W = 3;
    localparam int ADDR_W  = 16;
    localparam int ROW_MSB = 15;
    localparam int ROW_LSB = 8;
    localparam int COL_MSB = 7;
    localparam int COL_LSB = 0;

    localparam logic [DIGIT_W-1:0] PD_M2 = 3'b000;
    localparam logic [DIGIT_W-1:0] PD_M1 = 3'b001;
    localparam logic [DIGIT_W-1:0] PD_Z  = 3'b010;
    localparam logic [DIGIT_W-1:0] PD_P1 = 3'b011;
    localparam logic [DIGIT_W-1:0] PD_P2 = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_VERIFY,
        ST_COMPUTE,
        ST_DRAIN
    } xb_state_e;

    function automatic logic digit_valid(input logic [DIGIT_W-1:0] d);
        return d <= PD_P2;
    endfunction

endpackage

// File: rtl/pentary_xbar_rr_arbiter.sv
// Two-requester round-robin (write vs compute); on a tie the class not granted last wins.
module pentary_xbar_rr_arbiter (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic req_wr,
    input  logic req_cmp,
    output logic gnt_wr,
    output logic gnt_cmp
);

    logic last_wr;  // 1: write was granted most recently

    always_comb begin
        gnt_wr  = en & req_wr  & (~req_cmp | ~last_wr);
        gnt_cmp = en & req_cmp & (~req_wr  |  last_wr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        last_wr <= 1'b0;
        else if (gnt_wr)  last_wr <= 1'b1;
        else if (gnt_cmp) last_wr <= 1'b0;
    end

endmodule

// File: rtl/pentary_xbar_scheduler.sv
// Pentary crossbar scheduler: serializes weight programming and matrix-vector passes.
// Define XBAR_WRITE_VERIFY_EN to add read-back verify with bounded program retries.
module pentary_xbar_scheduler
    import pentary_xbar_pkg::*;
#(
    parameter int COMPUTE_CYCLES = 256,
    parameter int WRITE_CYCLES   = 4,
    parameter int MAX_RETRY      = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [DIGIT_W-1:0] wr_value,
    input  logic               cmp_valid,
    output logic               cmp_ready,
    output logic [ADDR_W-1:0]  xb_addr,
    output logic [DIGIT_W-1:0] xb_wdata,
    output logic               xb_we,
    output logic               xb_ce,
    input  logic               xb_ready,
    input  logic [DIGIT_W-1:0] xb_rdata,
    output logic               wr_done,
    output logic               cmp_done,
    output logic               wr_err,
    output logic               busy
);

    localparam int CNT_MAX = (COMPUTE_CYCLES > WRITE_CYCLES) ? COMPUTE_CYCLES : WRITE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    xb_state_e          state, state_n;
    logic [CNT_W-1:0]   cnt;
    logic [ADDR_W-1:0]  addr_q;
    logic [DIGIT_W-1:0] data_q;
    logic               is_wr_q;
    logic               err_q;
    logic               bypass_q;  // invalid code: no crossbar access, finish immediately
    logic               arb_en, wr_acc, cmp_acc, done_fire;

`ifdef XBAR_WRITE_VERIFY_EN
    localparam int RETRY_W = $clog2(MAX_RETRY + 2);
    logic [RETRY_W-1:0] retry_cnt;
    logic               rd_match;
    assign rd_match = (xb_rdata == data_q);
`else
    logic unused_rdata;
    assign unused_rdata = ^xb_rdata;
`endif

    // Gating with reset keeps the readies low while reset is held, even though state is IDLE.
    assign arb_en  = (state == ST_IDLE) & xb_ready & ~reset;
    assign wr_acc  = wr_ready  & wr_valid;
    assign cmp_acc = cmp_ready & cmp_valid;

    pentary_xbar_rr_arbiter u_arb (
        .clk     (clk),
        .reset   (reset),
        .en      (arb_en),
        .req_wr  (wr_valid),
        .req_cmp (cmp_valid),
        .gnt_wr  (wr_ready),
        .gnt_cmp (cmp_ready)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        xb_we     = 1'b0;
        xb_ce     = 1'b0;
        xb_addr   = '0;
        xb_wdata  = '0;
        done_fire = 1'b0;
        case (state)
            ST_IDLE: begin
                if (wr_acc)       state_n = digit_valid(wr_value) ? ST_WRITE : ST_DRAIN;
                else if (cmp_acc) state_n = ST_COMPUTE;
            end
            ST_WRITE: begin
                xb_we    = 1'b1;
                xb_addr  = addr_q;
                xb_wdata = data_q;
                if (cnt == CNT_W'(WRITE_CYCLES - 1)) begin
`ifdef XBAR_WRITE_VERIFY_EN
                    state_n = ST_VERIFY;
`else
                    state_n = ST_DRAIN;
`endif
                end
            end
`ifdef XBAR_WRITE_VERIFY_EN
            ST_VERIFY: begin
                xb_addr  = addr_q;
                xb_wdata = data_q;
                if (rd_match)                         state_n = ST_DRAIN;
                else if (retry_cnt < RETRY_W'(MAX_RETRY)) state_n = ST_WRITE;
                else                                  state_n = ST_DRAIN;
            end
`endif
            ST_COMPUTE: begin
                xb_ce = (cnt == '0);
                if (cnt == CNT_W'(COMPUTE_CYCLES - 1)) state_n = ST_DRAIN;
            end
            ST_DRAIN: begin
                done_fire = xb_ready | bypass_q;
                if (done_fire) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign wr_done  = done_fire & is_wr_q;
    assign cmp_done = done_fire & ~is_wr_q;
    assign wr_err   = done_fire & err_q;
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            is_wr_q  <= 1'b0;
            err_q    <= 1'b0;
            bypass_q <= 1'b0;
`ifdef XBAR_WRITE_VERIFY_EN
            retry_cnt <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
`ifdef XBAR_WRITE_VERIFY_EN
                    retry_cnt <= '0;
`endif
                    if (wr_acc) begin
                        addr_q   <= wr_addr;
                        data_q   <= wr_value;
                        is_wr_q  <= 1'b1;
                        err_q    <= ~digit_valid(wr_value);
                        bypass_q <= ~digit_valid(wr_value);
                    end else if (cmp_acc) begin
                        is_wr_q  <= 1'b0;
                        err_q    <= 1'b0;
                        bypass_q <= 1'b0;
                    end
                end
                ST_WRITE, ST_COMPUTE: cnt <= (state_n == state) ? cnt + 1'b1 : '0;
`ifdef XBAR_WRITE_VERIFY_EN
                ST_VERIFY: begin
                    cnt <= '0;
                    if (!rd_match) begin
                        if (retry_cnt < RETRY_W'(MAX_RETRY)) retry_cnt <= retry_cnt + 1'b1;
                        else                                 err_q     <= 1'b1;
                    end
                end
`endif
                default: cnt <= '0;
            endcase
        end
    end

endmodule
